// File: rtl/ysyx_22040632_bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040632_bpu_pkg
// Purpose  : Shared types and defaults for the branch prediction unit.
//            - default geometry (entries, PC width, counter width)
//            - BTB entry layout for the default geometry
//            - counter reset/allocation value (weakly taken)
//            - power-of-two helper for elaboration checks
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22040632_bpu_pkg;

    localparam int BPU_ENTRIES = 8;
    localparam int BPU_PC_W    = 32;
    localparam int BPU_CNT_W   = 2;

    // New entries start weakly taken: one taken resolution already observed.
    localparam logic [BPU_CNT_W-1:0] BPU_CNT_INIT = 2'b10;

    // Entry layout at the default geometry. The top module builds the same
    // layout from its own parameters so non-default widths also work.
    typedef struct packed {
        logic                 valid;
        logic [BPU_PC_W-1:0]  tag;
        logic [BPU_PC_W-1:0]  target;
        logic [BPU_CNT_W-1:0] cnt;
    } bpu_entry_t;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040632_bpu_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040632_bpu_if
// Purpose  : Fetch-side lookup and EX-side training bundle of the BPU.
// Signals  : flush                       - fence, invalidates the BTB
//            lk_pc / lk_hit / lk_taken /
//            lk_target                   - combinational fetch lookup
//            up_valid / up_pc /
//            up_target / up_taken        - branch resolution (training)
// Modports : master - pipeline side (IFU + EX), slave - the BPU
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_22040632_bpu_if #(
    parameter int PC_W = 32
);
    logic            flush;
    logic [PC_W-1:0] lk_pc;
    logic            lk_hit;
    logic            lk_taken;
    logic [PC_W-1:0] lk_target;
    logic            up_valid;
    logic [PC_W-1:0] up_pc;
    logic [PC_W-1:0] up_target;
    logic            up_taken;

    modport master (
        output flush, lk_pc, up_valid, up_pc, up_target, up_taken,
        input  lk_hit, lk_taken, lk_target
    );

    modport slave (
        input  flush, lk_pc, up_valid, up_pc, up_target, up_taken,
        output lk_hit, lk_taken, lk_target
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040632_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040632_sat_cnt
// Purpose  : Next-value logic of a saturating up/down counter (no state).
// Ports    : cnt     in  CNT_W  current value
//            inc     in  1      count up, holds at all-ones
//            dec     in  1      count down, holds at zero
//            cnt_nxt out CNT_W  next value (inc wins if both are set)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040632_sat_cnt #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt_nxt
);

    always_comb begin
        cnt_nxt = cnt;
        if (inc) begin
            if (!(&cnt)) cnt_nxt = cnt + CNT_W'(1);
        end else if (dec) begin
            if (|cnt) cnt_nxt = cnt - CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040632_bpu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040632_bpu
// Purpose  : Fully associative BTB with 2-bit direction counters and
//            round-robin replacement. Zero-latency lookup on the fetch PC,
//            training registered from the EX-stage branch resolution.
// Ports    : clk          in   clock
//            rrst_n       in   asynchronous active-low reset
//            bus          slave modport of ysyx_22040632_bpu_if
//            stat_hit     out  32  training hits       (stats build only)
//            stat_mispred out  32  mispredictions      (stats build only)
// Options  : YSYX_22040632_BPU_STATS_EN adds the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040632_bpu
    import ysyx_22040632_bpu_pkg::*;
#(
    parameter int ENTRIES = BPU_ENTRIES,
    parameter int PC_W    = BPU_PC_W,
    parameter int CNT_W   = BPU_CNT_W
) (
    input  logic                      clk,
    input  logic                      rrst_n,
    ysyx_22040632_bpu_if.slave        bus
`ifdef YSYX_22040632_BPU_STATS_EN
    ,
    output logic [31:0]               stat_hit,
    output logic [31:0]               stat_mispred
`endif
);

    localparam int PTR_W = $clog2(ENTRIES);
    // Weakly taken: MSB set, all other bits clear.
    localparam logic [CNT_W-1:0] CNT_INIT = {1'b1, {(CNT_W-1){1'b0}}};

    if (!is_pow2(ENTRIES) || ENTRIES < 2) begin : g_bad_entries
        $fatal(1, "ysyx_22040632_bpu: ENTRIES must be a power of two >= 2");
    end

    typedef struct packed {
        logic             valid;
        logic [PC_W-1:0]  tag;
        logic [PC_W-1:0]  target;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    entry_t             entries [ENTRIES];
    logic [PTR_W-1:0]   rr_ptr;
    logic [ENTRIES-1:0] lk_match;
    logic [ENTRIES-1:0] up_match;
    logic [CNT_W-1:0]   cnt_nxt [ENTRIES];
    logic               up_hit;
    logic               alloc;
    logic               lk_taken_c;
    logic [PC_W-1:0]    lk_target_c;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        assign lk_match[i] = entries[i].valid && (entries[i].tag == bus.lk_pc);
        assign up_match[i] = entries[i].valid && (entries[i].tag == bus.up_pc);

        ysyx_22040632_sat_cnt #(
            .CNT_W (CNT_W)
        ) u_sat_cnt (
            .cnt     (entries[i].cnt),
            .inc     (bus.up_valid && up_match[i] && bus.up_taken),
            .dec     (bus.up_valid && up_match[i] && !bus.up_taken),
            .cnt_nxt (cnt_nxt[i])
        );
    end

    // Tags are unique (updates hit in place), so the match vector is at
    // most one-hot and an AND-OR mux is sufficient.
    always_comb begin
        lk_taken_c  = 1'b0;
        lk_target_c = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (lk_match[i]) begin
                lk_taken_c  = lk_taken_c | entries[i].cnt[CNT_W-1];
                lk_target_c = lk_target_c | entries[i].target;
            end
        end
    end

    assign bus.lk_hit    = |lk_match;
    assign bus.lk_taken  = lk_taken_c;
    assign bus.lk_target = lk_target_c;

    assign up_hit = |up_match;
    // Only taken misses are worth a slot; not-taken misses already predict
    // correctly by missing.
    assign alloc  = bus.up_valid && !up_hit && bus.up_taken;

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
            rr_ptr <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
            rr_ptr <= '0;
        end else if (bus.up_valid) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (up_match[i]) begin
                    entries[i].cnt <= cnt_nxt[i];
                    if (bus.up_taken) entries[i].target <= bus.up_target;
                end else if (alloc && (rr_ptr == PTR_W'(i))) begin
                    entries[i].valid  <= 1'b1;
                    entries[i].tag    <= bus.up_pc;
                    entries[i].target <= bus.up_target;
                    entries[i].cnt    <= CNT_INIT;
                end
            end
            // Power-of-two depth: natural overflow is the modulo wrap.
            if (alloc) rr_ptr <= rr_ptr + PTR_W'(1);
        end
    end

`ifdef YSYX_22040632_BPU_STATS_EN
    logic            up_pred_taken;
    logic [PC_W-1:0] up_hit_target;
    logic            mispred;

    always_comb begin
        up_pred_taken = 1'b0;
        up_hit_target = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (up_match[i]) begin
                up_pred_taken = up_pred_taken | entries[i].cnt[CNT_W-1];
                up_hit_target = up_hit_target | entries[i].target;
            end
        end
    end

    assign mispred = (up_pred_taken != bus.up_taken) ||
                     (up_pred_taken && (up_hit_target != bus.up_target));

    // A resolution coincident with flush is discarded, including from the
    // statistics. Flush itself does not clear the counters.
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            stat_hit     <= '0;
            stat_mispred <= '0;
        end else if (bus.up_valid && !bus.flush) begin
            if (up_hit)  stat_hit     <= stat_hit + 32'd1;
            if (mispred) stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040632_bpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040632_bpu
// Purpose  : Self-checking bench for ysyx_22040632_bpu against a behavioural
//            BTB model (table search, integer counters clamped to 0..3).
// Options  : YSYX_22040632_BPU_STATS_EN also checks the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040632_bpu;
    import ysyx_22040632_bpu_pkg::*;

    localparam int ENTRIES = 8;
    localparam int PC_W    = 32;

    logic clk;
    logic rrst_n;
    int   total;
    int   bad;

    ysyx_22040632_bpu_if #(.PC_W(PC_W)) bus ();

`ifdef YSYX_22040632_BPU_STATS_EN
    logic [31:0] stat_hit;
    logic [31:0] stat_mispred;
`endif

    ysyx_22040632_bpu #(
        .ENTRIES (ENTRIES),
        .PC_W    (PC_W),
        .CNT_W   (2)
    ) dut (
        .clk          (clk),
        .rrst_n       (rrst_n),
        .bus          (bus)
`ifdef YSYX_22040632_BPU_STATS_EN
        ,
        .stat_hit     (stat_hit),
        .stat_mispred (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    int          m_ptr;
    logic [31:0] m_hits;
    logic [31:0] m_misp;

    function automatic int m_find(input logic [31:0] pc);
        for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && m_tag[i] == pc) return i;
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 0;
        end
        m_ptr = 0; m_hits = '0; m_misp = '0;
    endtask

    task automatic m_update(input bit fl, input bit uv, input logic [31:0] pc,
                            input logic [31:0] tgt, input bit tk);
        int  idx;
        bit  pred;
        if (fl) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
            m_ptr = 0;
            return;
        end
        if (!uv) return;
        idx  = m_find(pc);
        pred = (idx >= 0) && (m_cnt[idx] >= 2);
        if (idx >= 0) m_hits = m_hits + 1;
        if (pred != tk || (pred && m_tgt[idx] != tgt)) m_misp = m_misp + 1;
        if (idx >= 0) begin
            if (tk) begin
                m_tgt[idx] = tgt;
                m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
            end else begin
                m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
            end
        end else if (tk) begin
            m_valid[m_ptr] = 1; m_tag[m_ptr] = pc; m_tgt[m_ptr] = tgt; m_cnt[m_ptr] = 2;
            m_ptr = (m_ptr + 1) % ENTRIES;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [31:0] lk, input bit uv, input logic [31:0] upc,
                         input logic [31:0] utgt, input bit ut, input bit fl);
        bus.lk_pc = lk; bus.up_valid = uv; bus.up_pc = upc;
        bus.up_target = utgt; bus.up_taken = ut; bus.flush = fl;
    endtask

    task automatic clock_edge();
        m_update(bus.flush, bus.up_valid, bus.up_pc, bus.up_target, bus.up_taken);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rrst_n = 1'b0;
        drive(32'h8000_0000, 0, '0, '0, 0, 0);
        m_reset();
        #12;
        total++; if (bus.lk_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", bus.lk_hit); end
        total++; if (bus.lk_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", bus.lk_taken); end
        total++; if (bus.lk_target !== 32'h0) begin bad++; $display("FAIL reset_target got=%h exp=0", bus.lk_target); end
        total++; if (dut.rr_ptr !== 3'(m_ptr)) begin bad++; $display("FAIL reset_ptr got=%0d exp=%0d", dut.rr_ptr, m_ptr); end
`ifdef YSYX_22040632_BPU_STATS_EN
        total++; if (stat_hit !== m_hits || stat_mispred !== m_misp) begin
            bad++; $display("FAIL reset_stats got=%0d/%0d exp=%0d/%0d", stat_hit, stat_mispred, m_hits, m_misp);
        end
`endif
        @(negedge clk);
        rrst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alloc();
        drive(32'h8000_0000, 1, 32'h8000_0010, 32'h8000_0100, 1, 0);
        clock_edge();
        drive(32'h8000_0010, 0, '0, '0, 0, 0);
        @(negedge clk);
        total++; if (bus.lk_hit !== 1'b1) begin bad++; $display("FAIL alloc_hit got=%b exp=1", bus.lk_hit); end
        total++; if (bus.lk_taken !== 1'b1) begin bad++; $display("FAIL alloc_taken got=%b exp=1", bus.lk_taken); end
        total++; if (bus.lk_target !== 32'h8000_0100) begin bad++; $display("FAIL alloc_target got=%h exp=80000100", bus.lk_target); end
        clock_edge();
    endtask

    task automatic test_saturation();
        int idx;
        bit exp_tk;
        // 3 taken -> saturate high; 2 not-taken -> weakly not-taken.
        for (int k = 0; k < 3; k++) begin
            drive(32'h8000_0010, 1, 32'h8000_0010, 32'h8000_0100, 1, 0);
            clock_edge();
        end
        for (int k = 0; k < 2; k++) begin
            drive(32'h8000_0010, 1, 32'h8000_0010, 32'h8000_0100, 0, 0);
            clock_edge();
        end
        drive(32'h8000_0010, 0, '0, '0, 0, 0);
        @(negedge clk);
        total++; if (bus.lk_hit !== 1'b1) begin bad++; $display("FAIL sat_hit got=%b exp=1", bus.lk_hit); end
        total++; if (bus.lk_taken !== 1'b0) begin bad++; $display("FAIL sat_nt got=%b exp=0", bus.lk_taken); end
        // Two more not-taken (floor at 0), then one taken -> still not-taken.
        for (int k = 0; k < 3; k++) begin
            drive(32'h8000_0010, 1, 32'h8000_0010, 32'h8000_0100, (k == 2), 0);
            clock_edge();
        end
        drive(32'h8000_0010, 0, '0, '0, 0, 0);
        @(negedge clk);
        idx    = m_find(32'h8000_0010);
        exp_tk = (idx >= 0) && (m_cnt[idx] >= 2);
        total++; if (bus.lk_hit !== 1'b1 || bus.lk_taken !== exp_tk) begin
            bad++; $display("FAIL sat_floor got=%b/%b exp=1/%b", bus.lk_hit, bus.lk_taken, exp_tk);
        end
        clock_edge();
    endtask

    task automatic test_eviction();
        drive('0, 0, '0, '0, 0, 1);
        clock_edge();
        for (int i = 0; i <= ENTRIES; i++) begin
            drive('0, 1, 32'h8000_0000 + 32'(i) * 32'h10, 32'h9000_0000 + 32'(i), 1, 0);
            clock_edge();
        end
        for (int i = 0; i <= ENTRIES; i++) begin
            drive(32'h8000_0000 + 32'(i) * 32'h10, 0, '0, '0, 0, 0);
            @(negedge clk);
            total++;
            if (bus.lk_hit !== (i != 0) ||
                (i != 0 && bus.lk_target !== 32'h9000_0000 + 32'(i))) begin
                bad++; $display("FAIL evict_%0d got=%b/%h exp=%b", i, bus.lk_hit, bus.lk_target, (i != 0));
            end
            clock_edge();
        end
        total++; if (dut.rr_ptr !== 3'd1) begin bad++; $display("FAIL evict_ptr got=%0d exp=1", dut.rr_ptr); end
    endtask

    task automatic test_same_cycle();
        drive(32'h8000_0400, 1, 32'h8000_0400, 32'h8000_0800, 1, 0);
        @(negedge clk);
        total++; if (bus.lk_hit !== 1'b0) begin bad++; $display("FAIL same_cyc_miss got=%b exp=0", bus.lk_hit); end
        clock_edge();
        drive(32'h8000_0400, 0, '0, '0, 0, 0);
        @(negedge clk);
        total++; if (bus.lk_hit !== 1'b1 || bus.lk_target !== 32'h8000_0800) begin
            bad++; $display("FAIL same_cyc_hit got=%b/%h exp=1/80000800", bus.lk_hit, bus.lk_target);
        end
        clock_edge();
    endtask

    task automatic test_flush();
        logic [31:0] hits_before;
        // A training hit so the hit statistic is non-zero before the flush.
        drive('0, 1, 32'h8000_0020, 32'h9000_0002, 1, 0);
        clock_edge();
        hits_before = m_hits;
        drive('0, 1, 32'h8000_0700, 32'h8000_0900, 1, 1);
        clock_edge();
        for (int i = 0; i <= ENTRIES; i++) begin
            drive(32'h8000_0000 + 32'(i) * 32'h10, 0, '0, '0, 0, 0);
            #1;
            total++; if (bus.lk_hit !== 1'b0) begin bad++; $display("FAIL flush_miss_%0d got=%b exp=0", i, bus.lk_hit); end
        end
        drive(32'h8000_0700, 0, '0, '0, 0, 0);
        #1;
        total++; if (bus.lk_hit !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b exp=0", bus.lk_hit); end
        total++; if (dut.rr_ptr !== 3'd0) begin bad++; $display("FAIL flush_ptr got=%0d exp=0", dut.rr_ptr); end
`ifdef YSYX_22040632_BPU_STATS_EN
        total++; if (stat_hit !== hits_before) begin bad++; $display("FAIL flush_stat_hit got=%0d exp=%0d", stat_hit, hits_before); end
        drive('0, 1, 32'h8000_0a00, 32'h8000_0b00, 1, 0);
        clock_edge();
        drive('0, 1, 32'h8000_0a00, 32'h8000_0c00, 1, 0);
        clock_edge();
        total++; if (stat_mispred !== m_misp) begin bad++; $display("FAIL tgt_mispred got=%0d exp=%0d", stat_mispred, m_misp); end
`else
        hits_before = hits_before + 0;
`endif
    endtask

    task automatic test_async_reset();
        drive('0, 1, 32'h8000_0d00, 32'h8000_0e00, 1, 0);
        clock_edge();
        drive(32'h8000_0d00, 1, 32'h8000_0f00, 32'h8000_0e00, 1, 0);
        @(negedge clk);
        #2;
        rrst_n = 1'b0;
        m_reset();
        #1;
        total++; if (bus.lk_hit !== 1'b0) begin bad++; $display("FAIL arst_now got=%b exp=0", bus.lk_hit); end
        @(posedge clk);
        @(negedge clk);
        rrst_n = 1'b1;
        drive(32'h8000_0f00, 0, '0, '0, 0, 0);
        #1;
        total++; if (bus.lk_hit !== 1'b0 || dut.rr_ptr !== 3'd0) begin
            bad++; $display("FAIL arst_lost got=%b/%0d exp=0/0", bus.lk_hit, dut.rr_ptr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int          idx;
        bit          e_hit, e_tk;
        logic [31:0] e_tgt;
        for (int n = 0; n < 400; n++) begin
            drive(32'h8000_1000 + (32'($urandom_range(0, 11)) << 2),
                  ($urandom_range(0, 3) != 0),
                  32'h8000_1000 + (32'($urandom_range(0, 11)) << 2),
                  32'h9000_0000 + (32'($urandom_range(0, 3)) << 4),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 39) == 0);
            @(negedge clk);
            idx   = m_find(bus.lk_pc);
            e_hit = (idx >= 0);
            e_tk  = e_hit && (m_cnt[idx] >= 2);
            e_tgt = e_hit ? m_tgt[idx] : 32'h0;
            total++;
            if (bus.lk_hit !== e_hit || bus.lk_taken !== e_tk || bus.lk_target !== e_tgt) begin
                bad++; $display("FAIL rand_lookup_%0d got=%b/%b/%h exp=%b/%b/%h", n,
                                bus.lk_hit, bus.lk_taken, bus.lk_target, e_hit, e_tk, e_tgt);
            end
`ifdef YSYX_22040632_BPU_STATS_EN
            total++;
            if (stat_hit !== m_hits || stat_mispred !== m_misp) begin
                bad++; $display("FAIL rand_stats_%0d got=%0d/%0d exp=%0d/%0d", n,
                                stat_hit, stat_mispred, m_hits, m_misp);
            end
`endif
            clock_edge();
        end
        total++; if (dut.rr_ptr !== 3'(m_ptr)) begin bad++; $display("FAIL rand_ptr got=%0d exp=%0d", dut.rr_ptr, m_ptr); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alloc();
        test_saturation();
        test_eviction();
        test_same_cycle();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
